spi_tx_scheduler: RTL and testbench

- Sequences the 16-bit SPI serializer (spi_16) that drives the DAC from the OFDM transmitter (16-QAM, N=8, CP=4).
- Shares the serializer between two requesters: DAC configuration words, and I/Q time-domain samples from the CP-insertion stage.
- Each granted word is presented on spi_data/spi_valid for one fixed-length word slot, paced by an internal counter.
- Configuration words may only interleave between OFDM symbols, never inside one.

---
 rtl/ofdm_pkg.sv | 19 +
 rtl/spi_tx_scheduler_slot_timer.sv | 39 +++
 rtl/spi_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_spi_tx_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared definitions for the OFDM transmitter DAC path.
//   WORD_W   - width of one serializer word (config word or I/Q sample)
//   N, CP    - subcarriers and cyclic-prefix length; SYM_LEN = N + CP
//   sched_state_e - spi_tx_scheduler slot states
package ofdm_pkg;

    localparam int WORD_W  = 16;
    localparam int N       = 8;
    localparam int CP      = 4;
    localparam int SYM_LEN = N + CP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_SMP_I = 2'd2,
        ST_SMP_Q = 2'd3
    } sched_state_e;

endpackage

// File: rtl/spi_tx_scheduler_slot_timer.sv
// slot_timer: word-slot down-counter.
//   sclk    in  clock
//   reset_n in  async active-low reset
//   load    in  start a new slot (count <= WORD_CYCLES-1)
//   tc      out terminal count: last cycle of the current slot
// The counter parks at zero between slots, so tc is also high while idle.
module slot_timer #(
    parameter int WORD_CYCLES = 18
) (
    input  logic sclk,
    input  logic reset_n,
    input  logic load,
    output logic tc
);

    localparam int CW = $clog2(WORD_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WORD_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: shares the 16-bit SPI serializer between DAC config
// words and OFDM I/Q samples, one fixed-length word slot per word.
//   sclk, reset_n        clock, async active-low reset
//   cfg_req/cfg_word     config request and word; cfg_ack pulses on latch
//   smp_valid/i/q/last   I/Q sample source; smp_ready pulses on latch
//   spi_data/spi_valid   word and slot-active flag to the serializer
//   sym_err              sticky symbol-length error
//
// state    | meaning
// ST_IDLE  | no slot active, arbitrate every cycle
// ST_CFG   | slot carrying a config word
// ST_SMP_I | slot carrying an I sample (always followed by ST_SMP_Q)
// ST_SMP_Q | slot carrying the held Q sample
module spi_tx_scheduler
    import ofdm_pkg::*;
#(
    parameter int WORD_CYCLES = 18,
    parameter int SYM_LEN     = ofdm_pkg::SYM_LEN
) (
    input  logic              sclk,
    input  logic              reset_n,
    input  logic              cfg_req,
    input  logic [WORD_W-1:0] cfg_word,
    output logic              cfg_ack,
    input  logic              smp_valid,
    input  logic [WORD_W-1:0] smp_i,
    input  logic [WORD_W-1:0] smp_q,
    input  logic              smp_last,
    output logic              smp_ready,
    output logic [WORD_W-1:0] spi_data,
    output logic              spi_valid,
    output logic              sym_err
);

    localparam int CNT_W = $clog2(SYM_LEN) + 1;

    sched_state_e      state_q, state_d;
    logic [WORD_W-1:0] spi_data_q, spi_data_d;
    logic              spi_valid_q, spi_valid_d;
    logic              cfg_ack_q, cfg_ack_d;
    logic              smp_ready_q, smp_ready_d;
    logic [WORD_W-1:0] hold_q_q, hold_q_d;
    logic              last_q, last_d;
    logic              in_sym_q, in_sym_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic             load;
    logic             tc;
    logic             slot_end;
    logic             q_end;
    logic             sym_done;
    logic [CNT_W-1:0] cnt_base;

    slot_timer #(.WORD_CYCLES(WORD_CYCLES)) u_slot_timer (
        .sclk    (sclk),
        .reset_n (reset_n),
        .load    (load),
        .tc      (tc)
    );

    assign slot_end = (state_q != ST_IDLE) && tc;
    assign q_end    = (state_q == ST_SMP_Q) && tc;
    // The symbol closes at the end of its last Q slot; arbitration in that
    // same cycle already treats config as eligible again.
    assign sym_done = q_end && last_q;
    assign cnt_base = sym_done ? '0 : cnt_q;

    always_comb begin
        state_d     = state_q;
        spi_data_d  = spi_data_q;
        spi_valid_d = spi_valid_q;
        cfg_ack_d   = 1'b0;
        smp_ready_d = 1'b0;
        hold_q_d    = hold_q_q;
        last_d      = last_q;
        in_sym_d    = in_sym_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        load        = 1'b0;

        if (state_q == ST_SMP_I && slot_end) begin
            state_d    = ST_SMP_Q;
            spi_data_d = hold_q_q;
            load       = 1'b1;
        end else if (state_q == ST_IDLE || slot_end) begin
            if (q_end) begin
                if (last_q) begin
                    if (cnt_q != CNT_W'(SYM_LEN)) err_d = 1'b1;
                    in_sym_d = 1'b0;
                    cnt_d    = '0;
                    last_d   = 1'b0;
                end else if (cnt_q == CNT_W'(SYM_LEN)) begin
                    err_d = 1'b1;
                end
            end

            if (cfg_req && !(in_sym_q && !sym_done)) begin
                state_d     = ST_CFG;
                spi_data_d  = cfg_word;
                spi_valid_d = 1'b1;
                cfg_ack_d   = 1'b1;
                load        = 1'b1;
            end else if (smp_valid) begin
                state_d     = ST_SMP_I;
                spi_data_d  = smp_i;
                spi_valid_d = 1'b1;
                smp_ready_d = 1'b1;
                hold_q_d    = smp_q;
                last_d      = smp_last;
                in_sym_d    = 1'b1;
                // saturate so an overlong symbol cannot wrap back to SYM_LEN
                cnt_d       = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
                load        = 1'b1;
            end else begin
                state_d     = ST_IDLE;
                spi_data_d  = '0;
                spi_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            spi_data_q  <= '0;
            spi_valid_q <= 1'b0;
            cfg_ack_q   <= 1'b0;
            smp_ready_q <= 1'b0;
            hold_q_q    <= '0;
            last_q      <= 1'b0;
            in_sym_q    <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            spi_data_q  <= spi_data_d;
            spi_valid_q <= spi_valid_d;
            cfg_ack_q   <= cfg_ack_d;
            smp_ready_q <= smp_ready_d;
            hold_q_q    <= hold_q_d;
            last_q      <= last_d;
            in_sym_q    <= in_sym_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign spi_data  = spi_data_q;
    assign spi_valid = spi_valid_q;
    assign cfg_ack   = cfg_ack_q;
    assign smp_ready = smp_ready_q;
    assign sym_err   = err_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb_spi_tx_scheduler: randomized requesters plus a word-schedule reference
// model; every cycle the DUT outputs are compared against the model.
module tb_spi_tx_scheduler;

    localparam int WC = 18;
    localparam int SL = 12;

    logic        sclk;
    logic        reset_n;
    logic        cfg_req;
    logic [15:0] cfg_word;
    logic        cfg_ack;
    logic        smp_valid;
    logic [15:0] smp_i;
    logic [15:0] smp_q;
    logic        smp_last;
    logic        smp_ready;
    logic [15:0] spi_data;
    logic        spi_valid;
    logic        sym_err;

    spi_tx_scheduler #(.WORD_CYCLES(WC), .SYM_LEN(SL)) dut (
        .sclk      (sclk),
        .reset_n   (reset_n),
        .cfg_req   (cfg_req),
        .cfg_word  (cfg_word),
        .cfg_ack   (cfg_ack),
        .smp_valid (smp_valid),
        .smp_i     (smp_i),
        .smp_q     (smp_q),
        .smp_last  (smp_last),
        .smp_ready (smp_ready),
        .spi_data  (spi_data),
        .spi_valid (spi_valid),
        .sym_err   (sym_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // sched holds the words already granted; the front word is on the bus,
    // m_left counts its remaining cycles. A sample grant books I and Q together.
    logic [15:0] sched[$];
    int          m_left;
    bit          m_sym_open, m_pend_last, m_pair;
    int          m_cnt;
    bit          e_err, e_ack, e_rdy;

    task automatic model_reset();
        sched.delete();
        m_left = 0; m_sym_open = 0; m_pend_last = 0; m_pair = 0; m_cnt = 0;
        e_err = 0; e_ack = 0; e_rdy = 0;
    endtask

    task automatic model_step();
        bit decide;
        e_ack = 0;
        e_rdy = 0;
        decide = (sched.size() == 0) || (sched.size() == 1 && m_left == 1);
        if (!decide) begin
            if (m_left == 1) begin
                void'(sched.pop_front());
                m_left = WC;
            end else begin
                m_left--;
            end
        end else begin
            if (sched.size() == 1) begin
                void'(sched.pop_front());
                m_left = 0;
                if (m_pair) begin
                    m_pair = 0;
                    if (m_pend_last) begin
                        if (m_cnt != SL) e_err = 1;
                        m_sym_open = 0; m_cnt = 0; m_pend_last = 0;
                    end else if (m_cnt == SL) begin
                        e_err = 1;
                    end
                end
            end
            if (cfg_req && !m_sym_open) begin
                sched.push_back(cfg_word);
                m_left = WC;
                e_ack = 1;
            end else if (smp_valid) begin
                sched.push_back(smp_i);
                sched.push_back(smp_q);
                m_left = WC;
                e_rdy = 1;
                m_sym_open = 1;
                m_cnt++;
                m_pend_last = smp_last;
                m_pair = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [15:0] e_data;
        e_data = (sched.size() > 0) ? sched[0] : 16'h0;
        chk("spi_valid", 32'(spi_valid), 32'(sched.size() > 0));
        chk("spi_data",  32'(spi_data),  32'(e_data));
        chk("cfg_ack",   32'(cfg_ack),   32'(e_ack));
        chk("smp_ready", 32'(smp_ready), 32'(e_rdy));
        chk("sym_err",   32'(sym_err),   32'(e_err));
    endtask

    // ---------------- requesters ----------------
    logic [15:0] cfg_fifo[$];
    int          len_fifo[$];
    int cfg_rate = 100, smp_rate = 100, gap_rate = 0;
    int k = 0, cur_len = 0, sym_idx = 0, inject_at = -1;
    bit sym_active = 0;

    task automatic drive_smp();
        logic [7:0] si, kk;
        si = sym_idx[7:0];
        kk = k[7:0];
        smp_i    = {si, kk};
        smp_q    = ~{si, kk};
        smp_last = (k == cur_len - 1);
    endtask

    task automatic drive_sources();
        if (cfg_req && cfg_ack) begin
            cfg_req = 1'b0;
        end else if (!cfg_req && cfg_fifo.size() > 0 && $urandom_range(0, 99) < cfg_rate) begin
            cfg_word = cfg_fifo.pop_front();
            cfg_req  = 1'b1;
        end

        if (smp_valid && smp_ready) begin
            k++;
            if (k == cur_len) begin
                sym_active = 0;
                smp_valid  = 1'b0;
            end else if ($urandom_range(0, 99) < gap_rate) begin
                smp_valid = 1'b0;
            end else begin
                drive_smp();
            end
        end else if (!smp_valid) begin
            if (!sym_active && len_fifo.size() > 0) begin
                cur_len = len_fifo.pop_front();
                k = 0;
                sym_active = 1;
                sym_idx++;
            end
            if (sym_active && $urandom_range(0, 99) < smp_rate) begin
                drive_smp();
                smp_valid = 1'b1;
            end
        end

        if (inject_at >= 0 && sym_active && k == inject_at) begin
            cfg_fifo.push_back(16'h73AC);
            inject_at = -1;
        end
    endtask

    task automatic step_inputs();
        drive_sources();
        model_step();
    endtask

    task automatic cycle();
        @(negedge sclk);
        compare_outputs();
        step_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input int bound);
        bit drained;
        drained = 0;
        for (int i = 0; i < bound && !drained; i++) begin
            cycle();
            drained = (cfg_fifo.size() == 0) && (len_fifo.size() == 0) && !cfg_req &&
                      !smp_valid && !sym_active && (sched.size() == 0);
        end
        chk("drain", 32'(drained), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        cfg_req   = 1'b0;
        cfg_word  = 16'h0;
        smp_valid = 1'b0;
        smp_i     = 16'h0;
        smp_q     = 16'h0;
        smp_last  = 1'b0;
        model_reset();

        @(negedge sclk);
        @(negedge sclk);
        compare_outputs();
        reset_n = 1'b1;
        step_inputs();

        // single config word
        cfg_fifo.push_back(16'hA5A5);
        run_until_idle(60);

        // one full symbol, config raised at sample 3 must wait for Q11
        len_fifo.push_back(SL);
        inject_at = 3;
        run_until_idle(SL * 2 * WC + 3 * WC);

        // config and sample rising in the same idle cycle
        cfg_fifo.push_back(16'h0123);
        len_fifo.push_back(SL);
        run_until_idle(SL * 2 * WC + 3 * WC);

        // short symbol then a correct one; error stays set
        len_fifo.push_back(10);
        len_fifo.push_back(SL);
        run_until_idle(22 * 2 * WC + 3 * WC);
        chk("sym_err_sticky", 32'(sym_err), 32'd1);

        // asynchronous reset in the middle of an I slot
        len_fifo.push_back(SL);
        run(6);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_spi_valid", 32'(spi_valid), 32'd0);
        chk("rst_spi_data",  32'(spi_data),  32'd0);
        chk("rst_cfg_ack",   32'(cfg_ack),   32'd0);
        chk("rst_smp_ready", 32'(smp_ready), 32'd0);
        chk("rst_sym_err",   32'(sym_err),   32'd0);
        model_reset();
        k = 0;
        drive_smp();
        @(negedge sclk);
        reset_n = 1'b1;
        step_inputs();
        run_until_idle(SL * 2 * WC + 3 * WC);

        // randomized traffic
        cfg_rate = 30;
        smp_rate = 60;
        gap_rate = 10;
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 5) == 0) len_fifo.push_back(int'($urandom_range(9, 14)));
            else len_fifo.push_back(SL);
        end
        for (int c = 0; c < 20; c++) cfg_fifo.push_back(16'($urandom));
        run_until_idle(40000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
